// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: opcodes, default widths and the master-arbiter state type.
// Also holds the modulo-3 helper used for round-robin pointer arithmetic.
package tlul_pkg;

    localparam int TL_AW       = 32;
    localparam int TL_DW       = 32;
    localparam int TL_SZW      = 3;
    localparam int TL_AIW      = 2;
    localparam int TL_DIW      = 1;
    localparam int TL_OPW      = 3;
    localparam int TL_PW       = 3;
    localparam int NUM_MASTERS = 3;

    localparam logic [2:0] OP_GET             = 3'd4;
    localparam logic [2:0] OP_PUT_FULL_DATA   = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Result is always in 0..2, even for the unreachable operand value 3.
    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = 3'(a) + 3'(b);
        if (s >= 3'd3) s = s - 3'd3;
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

endpackage

// File: rtl/tlul_master_arbiter_rr_pick3.sv
// Round-robin picker for three requesters: returns the first eligible index at or
// after rr_ptr, wrapping modulo 3.
module rr_pick3
    import tlul_pkg::*;
(
    input  logic [2:0] eligible,
    input  logic [1:0] rr_ptr,
    output logic [1:0] grant,
    output logic       any
);

    logic [1:0] idx;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        grant = 2'd0;
        any   = 1'b0;
        idx   = 2'd0;
        // Walk from farthest to nearest so the nearest eligible index is the last writer.
        for (int off = 2; off >= 0; off--) begin
            idx = mod3_add(rr_ptr, 2'(off));
            if (eligible[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlul_master_arbiter.sv
// Three-master TL-UL A-channel arbiter with D-channel response routing by source index.
// Each master may have one outstanding transaction; its original source is restored on D.
module tlul_master_arbiter
    import tlul_pkg::*;
#(
    parameter int ADDR_WIDTH   = TL_AW,
    parameter int DATA_WIDTH   = TL_DW,
    parameter int MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int SIZE_WIDTH   = TL_SZW,
    parameter int SRC_WIDTH    = TL_AIW,
    parameter int SINK_WIDTH   = TL_DIW,
    parameter int OPCODE_WIDTH = TL_OPW,
    parameter int PARAM_WIDTH  = TL_PW
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_MASTERS-1:0]              m_a_valid,
    output logic [NUM_MASTERS-1:0]              m_a_ready,
    input  logic [NUM_MASTERS*OPCODE_WIDTH-1:0] m_a_opcode,
    input  logic [NUM_MASTERS*PARAM_WIDTH-1:0]  m_a_param,
    input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]   m_a_size,
    input  logic [NUM_MASTERS*SRC_WIDTH-1:0]    m_a_source,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_a_address,
    input  logic [NUM_MASTERS*MASK_WIDTH-1:0]   m_a_mask,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_a_data,
    output logic                                a_valid_out,
    input  logic                                a_ready_out,
    output logic [OPCODE_WIDTH-1:0]             a_opcode_out,
    output logic [PARAM_WIDTH-1:0]              a_param_out,
    output logic [SIZE_WIDTH-1:0]               a_size_out,
    output logic [SRC_WIDTH-1:0]                a_source_out,
    output logic [ADDR_WIDTH-1:0]               a_address_out,
    output logic [MASK_WIDTH-1:0]               a_mask_out,
    output logic [DATA_WIDTH-1:0]               a_data_out,
    input  logic                                d_valid_in,
    output logic                                d_ready_in,
    input  logic [OPCODE_WIDTH-1:0]             d_opcode_in,
    input  logic [PARAM_WIDTH-1:0]              d_param_in,
    input  logic [SIZE_WIDTH-1:0]               d_size_in,
    input  logic [SRC_WIDTH-1:0]                d_source_in,
    input  logic [SINK_WIDTH-1:0]               d_sink_in,
    input  logic [DATA_WIDTH-1:0]               d_data_in,
    input  logic                                d_error_in,
    output logic [NUM_MASTERS-1:0]              m_d_valid,
    input  logic [NUM_MASTERS-1:0]              m_d_ready,
    output logic [NUM_MASTERS*OPCODE_WIDTH-1:0] m_d_opcode,
    output logic [NUM_MASTERS*PARAM_WIDTH-1:0]  m_d_param,
    output logic [NUM_MASTERS*SIZE_WIDTH-1:0]   m_d_size,
    output logic [NUM_MASTERS*SRC_WIDTH-1:0]    m_d_source,
    output logic [NUM_MASTERS*SINK_WIDTH-1:0]   m_d_sink,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_d_data,
    output logic [NUM_MASTERS-1:0]              m_d_error,
    output logic [NUM_MASTERS-1:0]              pending,
    output logic                                err_unrouted
);

    arb_state_e             state_q, state_d;
    logic [1:0]             grant_q, grant_d;
    logic [1:0]             rr_ptr_q, rr_ptr_d;
    logic [NUM_MASTERS-1:0] pending_q, pending_d;
    logic                   err_q, err_d;
    logic [SRC_WIDTH-1:0]   src_save_q [NUM_MASTERS];
    logic [SRC_WIDTH-1:0]   src_save_d [NUM_MASTERS];

    logic [NUM_MASTERS-1:0] eligible;
    logic [1:0]             pick_grant;
    logic                   pick_any;
    logic                   a_hs;
    logic                   d_hs;
    logic                   d_routable;

    assign eligible   = m_a_valid & ~pending_q;
    assign a_hs       = (state_q == BUSY) && a_ready_out;
    assign d_hs       = d_valid_in && d_ready_in;
    assign d_routable = d_source_in < SRC_WIDTH'(NUM_MASTERS);

    rr_pick3 u_rr_pick3 (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .grant    (pick_grant),
        .any      (pick_any)
    );

    // A channel: the granted slice is forwarded only while BUSY; otherwise all zero.
    always_comb begin
        a_valid_out   = (state_q == BUSY);
        m_a_ready     = '0;
        a_opcode_out  = '0;
        a_param_out   = '0;
        a_size_out    = '0;
        a_source_out  = '0;
        a_address_out = '0;
        a_mask_out    = '0;
        a_data_out    = '0;
        if (state_q == BUSY) begin
            a_source_out = SRC_WIDTH'(grant_q);
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (grant_q == 2'(i)) begin
                    m_a_ready[i]  = a_ready_out;
                    a_opcode_out  = m_a_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH];
                    a_param_out   = m_a_param[i*PARAM_WIDTH +: PARAM_WIDTH];
                    a_size_out    = m_a_size[i*SIZE_WIDTH +: SIZE_WIDTH];
                    a_address_out = m_a_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                    a_mask_out    = m_a_mask[i*MASK_WIDTH +: MASK_WIDTH];
                    a_data_out    = m_a_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign m_d_opcode = {NUM_MASTERS{d_opcode_in}};
    assign m_d_param  = {NUM_MASTERS{d_param_in}};
    assign m_d_size   = {NUM_MASTERS{d_size_in}};
    assign m_d_sink   = {NUM_MASTERS{d_sink_in}};
    assign m_d_data   = {NUM_MASTERS{d_data_in}};
    assign m_d_error  = {NUM_MASTERS{d_error_in}};

    // D channel: an out-of-range source is sunk so the slave never stalls on it.
    always_comb begin
        m_d_valid  = '0;
        d_ready_in = 1'b1;
        m_d_source = {NUM_MASTERS{d_source_in}};
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (d_source_in == SRC_WIDTH'(i)) begin
                m_d_valid[i]                          = d_valid_in;
                d_ready_in                            = m_d_ready[i];
                m_d_source[i*SRC_WIDTH +: SRC_WIDTH]  = src_save_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        pending_d  = pending_q;
        err_d      = err_q;
        src_save_d = src_save_q;

        if (d_valid_in && !d_routable) err_d = 1'b1;
        // Clear before set so a D completion and a new A accept for different masters both land.
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (d_hs && d_source_in == SRC_WIDTH'(i)) pending_d[i] = 1'b0;
            if (a_hs && grant_q == 2'(i)) begin
                pending_d[i]  = 1'b1;
                src_save_d[i] = m_a_source[i*SRC_WIDTH +: SRC_WIDTH];
            end
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (a_ready_out) begin
                    rr_ptr_d = mod3_add(grant_q, 2'd1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= 2'd0;
            rr_ptr_q  <= 2'd0;
            pending_q <= '0;
            err_q     <= 1'b0;
            // NOTE: the saved-source array is small and must read back zero after reset, so it is cleared.
            for (int i = 0; i < NUM_MASTERS; i++) src_save_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            pending_q  <= pending_d;
            err_q      <= err_d;
            src_save_q <= src_save_d;
        end
    end

    assign pending      = pending_q;
    assign err_unrouted = err_q;

endmodule
